dbus_bridge: RTL and testbench

//  Data-side slave that sits directly downstream of the core's d_* load/store port.

---
 rtl/dbus_pkg.sv | 29 ++
 rtl/dbus_sram.sv | 38 +++
 rtl/dbus_bridge.sv | 191 +++++++++++++++++++
 tb/tb_dbus_bridge.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// ============================================================================
// dbus_pkg : address-region and FSM-state definitions for the data-bus bridge
// Rev 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;

  typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_e;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE      = 2'd0;
  localparam state_e ST_RAM_RD    = 2'd1;
  localparam state_e ST_MMIO_WAIT = 2'd2;
  localparam state_e ST_RESP      = 2'd3;

  localparam logic [3:0] RGN_RAM_TAG  = 4'h0;
  localparam logic [3:0] RGN_MMIO_TAG = 4'h4;

  // Takes only the top nibble of the byte address.
  function automatic region_e decode_region(input logic [3:0] tag);
    if (tag == RGN_RAM_TAG)       return RGN_RAM;
    else if (tag == RGN_MMIO_TAG) return RGN_MMIO;
    else                          return RGN_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_sram.sv
// ============================================================================
// dbus_sram : single-port byte-enabled SRAM, one-cycle synchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module dbus_sram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dbus_bridge.sv
// ============================================================================
// dbus_bridge : core data-port slave decoding into SRAM, MMIO or unmapped space
// Rev 1.0
// ============================================================================
`default_nettype none

module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int          RAM_AW   = 10,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  input  logic [3:0]  d_wr_be,
  input  logic [31:0] d_wr_data,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        d_wr_ready_q, d_wr_ready_d;
  logic        d_rd_ready_q, d_rd_ready_d;
  logic [31:0] d_rd_data_q, d_rd_data_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        bus_err_q, bus_err_d;

  logic        sram_en, sram_we;
  logic [31:0] sram_rdata;
  region_e     rgn;

  assign rgn = decode_region(d_addr[31:28]);

  always_comb begin
    state_d      = state_q;
    is_rd_d      = is_rd_q;
    cnt_d        = cnt_q;
    d_wr_ready_d = 1'b0;
    d_rd_ready_d = 1'b0;
    d_rd_data_d  = d_rd_data_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_be_d       = m_be_q;
    m_wdata_d    = m_wdata_q;
    bus_err_d    = bus_err_q;
    sram_en      = 1'b0;
    sram_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A read beats a simultaneous write; the write stays held and is taken later.
        if (d_rd_req || d_wr_req) begin
          is_rd_d = d_rd_req;
          case (rgn)
            RGN_RAM: begin
              sram_en = 1'b1;
              sram_we = !d_rd_req;
              if (d_rd_req) begin
                state_d = ST_RAM_RD;
              end else begin
                d_wr_ready_d = 1'b1;
                state_d      = ST_RESP;
              end
            end
            RGN_MMIO: begin
              m_req_d   = 1'b1;
              m_we_d    = !d_rd_req;
              m_addr_d  = d_addr;
              m_be_d    = d_rd_req ? 4'hF : d_wr_be;
              m_wdata_d = d_rd_req ? 32'h0 : d_wr_data;
              cnt_d     = '0;
              state_d   = ST_MMIO_WAIT;
            end
            default: begin
              bus_err_d    = 1'b1;
              d_rd_ready_d = d_rd_req;
              d_wr_ready_d = !d_rd_req;
              if (d_rd_req) d_rd_data_d = ERR_DATA;
              state_d      = ST_RESP;
            end
          endcase
        end
      end
      ST_RAM_RD: begin
        d_rd_data_d  = sram_rdata;
        d_rd_ready_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_MMIO_WAIT: begin
        // An ack arriving on the last counted cycle still completes normally.
        if (m_ack) begin
          m_req_d      = 1'b0;
          d_rd_ready_d = is_rd_q;
          d_wr_ready_d = !is_rd_q;
          if (is_rd_q) d_rd_data_d = m_rdata;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          m_req_d      = 1'b0;
          bus_err_d    = 1'b1;
          d_rd_ready_d = is_rd_q;
          d_wr_ready_d = !is_rd_q;
          if (is_rd_q) d_rd_data_d = ERR_DATA;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_rd_q      <= 1'b0;
      cnt_q        <= '0;
      d_wr_ready_q <= 1'b0;
      d_rd_ready_q <= 1'b0;
      d_rd_data_q  <= 32'h0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 32'h0;
      m_be_q       <= 4'h0;
      m_wdata_q    <= 32'h0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_rd_q      <= is_rd_d;
      cnt_q        <= cnt_d;
      d_wr_ready_q <= d_wr_ready_d;
      d_rd_ready_q <= d_rd_ready_d;
      d_rd_data_q  <= d_rd_data_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_be_q       <= m_be_d;
      m_wdata_q    <= m_wdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  dbus_sram #(
    .RAM_AW (RAM_AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en && !rst),
    .we    (sram_we),
    .be    (d_wr_be),
    .addr  (d_addr[RAM_AW+1:2]),
    .wdata (d_wr_data),
    .rdata (sram_rdata)
  );

  assign d_wr_ready = d_wr_ready_q;
  assign d_rd_ready = d_rd_ready_q;
  assign d_rd_data  = d_rd_data_q;
  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_be       = m_be_q;
  assign m_wdata    = m_wdata_q;
  assign bus_err    = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_bridge.sv
// ============================================================================
// tb_dbus_bridge : randomized scoreboard bench for dbus_bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dbus_bridge;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr;
  logic        d_wr_req;
  logic [3:0]  d_wr_be;
  logic [31:0] d_wr_data;
  logic        d_wr_ready;
  logic        d_rd_req;
  logic        d_rd_ready;
  logic [31:0] d_rd_data;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        bus_err;

  dbus_bridge #(
    .RAM_AW   (10),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d_addr     (d_addr),
    .d_wr_req   (d_wr_req),
    .d_wr_be    (d_wr_be),
    .d_wr_data  (d_wr_data),
    .d_wr_ready (d_wr_ready),
    .d_rd_req   (d_rd_req),
    .d_rd_ready (d_rd_ready),
    .d_rd_data  (d_rd_data),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_be       (m_be),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
    bit          err;
  } exp_t;
  exp_t sb[$];

  // Reference state: word-addressed RAM image, last returned load word, sticky error.
  logic [31:0] mem_m [1024];
  logic [31:0] last_rd = 32'h0;
  bit          err_m   = 1'b0;

  // Expectations handed to the MMIO responder for the transaction in flight.
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [3:0]  mm_be;
  logic [31:0] mm_wdata;
  int          mm_dly;
  logic [31:0] mm_rdata;
  int          mm_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (d_rd_ready || d_wr_ready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {30'h0, d_rd_ready, d_wr_ready}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("ready_kind", {30'h0, d_rd_ready, d_wr_ready}, {30'h0, e.is_rd, !e.is_rd});
        chk("rd_data", d_rd_data, e.data);
        chk("ready_cycle", cyc, e.cyc);
        chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
      end
    end
  end

  // MMIO responder: acks mm_dly cycles after m_req rises (never if beyond the timeout).
  initial begin
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    forever begin : resp_loop
      int k;
      @(negedge clk);
      if (m_req === 1'b1 && !rst) begin
        chk("m_we", {31'h0, m_we}, {31'h0, mm_we});
        chk("m_addr", m_addr, mm_addr);
        chk("m_be", {28'h0, m_be}, {28'h0, mm_be});
        if (mm_we) chk("m_wdata", m_wdata, mm_wdata);
        k = 0;
        while (m_req === 1'b1 && k < 200) begin
          m_ack   = (k == mm_dly);
          m_rdata = (k == mm_dly) ? mm_rdata : $urandom();
          @(negedge clk);
          k++;
        end
        m_ack = 1'b0;
        if (mm_hi >= 0) chk("m_req_high_cycles", k, mm_hi);
      end
    end
  end

  task automatic wait_ready(input bit is_rd);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_rd ? d_rd_ready : d_wr_ready) && n < 100);
    if (!(is_rd ? d_rd_ready : d_wr_ready)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none expected=%s ready", is_rd ? "rd" : "wr");
    end
  endtask

  task automatic run_op(input bit is_rd, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int dly, input logic [31:0] mrd);
    exp_t e;
    int   lat;
    if (addr[31:28] == 4'h0) begin
      if (is_rd) begin
        lat     = 2;
        last_rd = mem_m[addr[11:2]];
      end else begin
        lat = 1;
        mem_m[addr[11:2]] = merge(mem_m[addr[11:2]], wd, be);
      end
    end else if (addr[31:28] == 4'h4) begin
      mm_we    = !is_rd;
      mm_addr  = addr;
      mm_be    = is_rd ? 4'hF : be;
      mm_wdata = wd;
      mm_dly   = dly;
      mm_rdata = mrd;
      if (dly < TIMEOUT) begin
        lat   = 2 + dly;
        mm_hi = dly + 1;
        if (is_rd) last_rd = mrd;
      end else begin
        lat   = TIMEOUT + 1;
        mm_hi = TIMEOUT;
        err_m = 1'b1;
        if (is_rd) last_rd = ERR;
      end
    end else begin
      lat   = 1;
      err_m = 1'b1;
      if (is_rd) last_rd = ERR;
    end
    e.is_rd = is_rd;
    e.data  = last_rd;
    e.err   = err_m;
    @(posedge clk); #1;
    e.cyc = cyc + lat;
    sb.push_back(e);
    d_addr    = addr;
    d_wr_be   = be;
    d_wr_data = wd;
    if (is_rd) d_rd_req = 1'b1;
    else       d_wr_req = 1'b1;
    wait_ready(is_rd);
    @(posedge clk); #1;
    d_rd_req = 1'b0;
    d_wr_req = 1'b0;
  endtask

  // Load and store raised together on a RAM address: load returns the old word first.
  task automatic run_both(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    exp_t er, ew;
    last_rd = mem_m[addr[11:2]];
    er.is_rd = 1'b1; er.data = last_rd; er.err = err_m;
    mem_m[addr[11:2]] = merge(mem_m[addr[11:2]], wd, be);
    ew.is_rd = 1'b0; ew.data = last_rd; ew.err = err_m;
    @(posedge clk); #1;
    er.cyc = cyc + 2;
    ew.cyc = cyc + 4;
    sb.push_back(er);
    sb.push_back(ew);
    d_addr = addr; d_wr_be = be; d_wr_data = wd;
    d_rd_req = 1'b1; d_wr_req = 1'b1;
    wait_ready(1'b1);
    @(posedge clk); #1;
    d_rd_req = 1'b0;
    wait_ready(1'b0);
    @(posedge clk); #1;
    d_wr_req = 1'b0;
  endtask

  function automatic logic [31:0] ram_addr();
    logic [15:0] hi;
    logic [3:0]  w;
    logic [1:0]  b;
    hi = 16'($urandom());
    w  = 4'($urandom());
    b  = 2'($urandom());
    return {4'h0, hi, 6'h0, w, b};
  endfunction

  initial begin
    int n;
    rst = 1'b1; d_addr = 32'h0; d_wr_req = 1'b0; d_wr_be = 4'h0;
    d_wr_data = 32'h0; d_rd_req = 1'b0; mm_hi = -1; mm_dly = 0;
    mm_we = 1'b0; mm_addr = 32'h0; mm_be = 4'h0; mm_wdata = 32'h0; mm_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", {31'h0, d_wr_ready}, 32'h0);
    chk("rst_rd_ready", {31'h0, d_rd_ready}, 32'h0);
    chk("rst_rd_data", d_rd_data, 32'h0);
    chk("rst_m_req", {31'h0, m_req}, 32'h0);
    chk("rst_m_we", {31'h0, m_we}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_be", {28'h0, m_be}, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);

    for (int i = 0; i < 16; i++)
      run_op(1'b0, 32'(i * 4), 4'hF, (i == 4) ? 32'h0 : $urandom(), 0, 32'h0);

    run_op(1'b0, 32'h0000_0011, 4'h2, 32'h0000_AB00, 0, 32'h0);
    run_op(1'b1, 32'h0000_0010, 4'h0, 32'h0, 0, 32'h0);
    run_op(1'b1, 32'h0000_1010, 4'h0, 32'h0, 0, 32'h0);
    run_both(32'h0000_0020, 4'hC, 32'h5A5A_0000);
    run_op(1'b1, 32'h0000_0020, 4'h0, 32'h0, 0, 32'h0);
    run_op(1'b1, 32'h4000_0008, 4'h0, 32'h0, 3, 32'h1234_5678);
    run_op(1'b1, 32'h4000_0010, 4'h0, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
    run_op(1'b0, 32'h4000_000C, 4'hF, 32'h0BAD_F00D, 1000, 32'h0);
    run_op(1'b1, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h0);

    // Reset while an MMIO read is stalled: no response, RAM survives.
    mm_we = 1'b0; mm_addr = 32'h4000_0100; mm_be = 4'hF; mm_dly = 1000; mm_hi = -1;
    @(posedge clk); #1;
    d_addr = 32'h4000_0100; d_rd_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("mmio_wait_m_req", {31'h0, m_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; d_rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    err_m = 1'b0; last_rd = 32'h0;
    @(negedge clk);
    chk("rst_mid_m_req", {31'h0, m_req}, 32'h0);
    chk("rst_mid_bus_err", {31'h0, bus_err}, 32'h0);
    repeat (3) @(negedge clk);
    run_op(1'b1, 32'h0000_0010, 4'h0, 32'h0, 0, 32'h0);
    run_op(1'b1, 32'h0000_003C, 4'h0, 32'h0, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      int sel;
      logic [3:0] tag;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: run_op(1'b1, ram_addr(), 4'h0, 32'h0, 0, 32'h0);
        2, 3:    run_op(1'b0, ram_addr(), 4'($urandom()), $urandom(), 0, 32'h0);
        4, 5, 6: run_op(1'($urandom()), {4'h4, 28'($urandom())}, 4'($urandom()), $urandom(),
                        $urandom_range(0, TIMEOUT + 1), $urandom());
        7: begin
          tag = 4'($urandom_range(1, 15));
          if (tag == 4'h4) tag = 4'h5;
          run_op(1'($urandom()), {tag, 28'($urandom())}, 4'($urandom()), $urandom(), 0, 32'h0);
        end
        default: run_both(ram_addr(), 4'($urandom()), $urandom());
      endcase
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
